triumph_imem_arbiter: RTL and testbench
=======================================

Name: triumph_imem_arbiter

Overview:
- Shares the single-port instruction memory between the IF-stage fetch port and a loader/debug port.
- The loader port writes programs into instruction memory and reads them back.
- Fetch has priority. An anti-starvation run counter and a loader lock guarantee loader progress and atomic bursts.
- Sits between the IF stage, the boot/debug loader and the instruction RAM, which has 1-cycle read latency and is always ready.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_FETCH_RUN, 8, consecutive fetch grants allowed while the loader waits before the loader is forced in (range 1..255)

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset; asynchronous, active-high
f_req_i  input  1  fetch read request
f_addr_i  input  AW  fetch address
f_gnt_o  output  1  fetch request accepted this cycle
f_rvalid_o  output  1  fetch read data valid
f_rdata_o  output  DW  fetch read data
l_req_i  input  1  loader request
l_we_i  input  1  loader write enable
l_lock_i  input  1  loader holds the port after this grant
l_addr_i  input  AW  loader address
l_wdata_i  input  DW  loader write data
l_gnt_o  output  1  loader request accepted this cycle
l_rvalid_o  output  1  loader read data valid (reads only)
l_rdata_o  output  DW  loader read data
mem_req_o  output  1  memory access
mem_we_o  output  1  memory write
mem_addr_o  output  AW  memory address
mem_wdata_o  output  DW  memory write data
mem_rdata_i  input  DW  memory read data, valid 1 cycle after a read request
fetch_stall_o  output  1  f_req_i and not f_gnt_o

Behaviour:
- Reset (rstn_i=1, asynchronous, active-high):
  - state=ST_FETCH, run_cnt=0, outstanding-read owner cleared.
  - All outputs 0: every gnt, rvalid, rdata and mem_* output.
  - In-flight reads are discarded; no rvalid is produced after reset.
- Grants are combinational in the request cycle. At most one grant per cycle.
- mem_req_o = f_gnt_o | l_gnt_o. mem_we/addr/wdata are muxed from the granted port; all 0 when idle.
- Fetch never writes.
- State ST_FETCH:
  - l_gnt_o = l_req_i & (~f_req_i | run_cnt==MAX_FETCH_RUN).
  - f_gnt_o = f_req_i & ~l_gnt_o.
- State ST_LOCK:
  - l_gnt_o = l_req_i; f_gnt_o = 0.
  - Fetch stalls even if the loader is idle that cycle.
- State transitions:
  - ST_FETCH -> ST_LOCK when l_gnt_o & l_lock_i.
  - ST_LOCK -> ST_FETCH when (l_gnt_o & ~l_lock_i) or ~l_req_i.
  - The unlocking grant still executes.
- run_cnt (8-bit, registered):
  - Increments on f_gnt_o & l_req_i.
  - Saturates at MAX_FETCH_RUN.
  - Clears to 0 on l_gnt_o or when l_req_i=0.
- Read response:
  - A registered owner bit (with valid) is captured for each read grant.
  - The next cycle asserts exactly one of f_rvalid_o/l_rvalid_o for one cycle.
  - The rdata of the owning port = mem_rdata_i; the rdata of the other port = 0.
  - Loader writes produce no rvalid.
- Back-to-back: a new grant is allowed every cycle. A response and a new grant may coincide, including to different owners.
- Requesters must hold req/addr/wdata/we stable until granted. Behaviour with changing inputs before grant is undefined.
- Simultaneous f_req_i & l_req_i with run_cnt<MAX_FETCH_RUN in ST_FETCH: fetch wins.
- MAX_FETCH_RUN counting: with both requesting continuously, the pattern is MAX_FETCH_RUN fetch grants, then 1 loader grant, repeating.

Test Plan:
- Fetch only: f_req_i=1, addr 0,1,2 on consecutive cycles; mem_rdata echoes addr+0x100 -> f_gnt_o=1 each cycle, f_rvalid_o one cycle later with f_rdata_o 0x100,0x101,0x102; l_rvalid_o=0.
- Contention: both request continuously, MAX_FETCH_RUN=8 -> grant sequence F×8, L, F×8, L. run_cnt peaks at 8 and clears on each L grant. fetch_stall_o=1 exactly on L cycles.
- Loader burst write: l_lock_i=1 for 4 writes to 0x10..0x13 with wdata 0xA0..0xA3, f_req_i=1 throughout -> f_gnt_o=0 for 4 cycles, mem_we_o=1 with correct addr/data. Last write with l_lock_i=0 returns to ST_FETCH; the fetch grant is issued the next cycle.
- Lock with gap: lock grant, then l_req_i=0 one cycle -> that cycle f_gnt_o=0 and state returns to ST_FETCH. Fetch is granted the following cycle.
- Loader read after fetch read back-to-back: F read addr 5, L read addr 9 in the next cycle -> f_rvalid_o then l_rvalid_o on successive cycles, each carrying its own mem_rdata_i; the other port's rdata=0.
- Async reset mid-read: assert rstn_i between a read grant and its response cycle -> all outputs 0 immediately, no rvalid after release, run_cnt=0, state ST_FETCH.

Source files
------------

// File: rtl/triumph_imem_arbiter.sv
// Arbitrates the single-port instruction RAM between IF-stage fetch and the loader/debug port.
// Fetch has priority; a run counter forces the loader in, and a lock keeps loader bursts atomic.
module triumph_imem_arbiter #(
   parameter int AW            = 32,
   parameter int DW            = 32,
   parameter int MAX_FETCH_RUN = 8
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          f_req_i,
   input  logic [AW-1:0] f_addr_i,
   output logic          f_gnt_o,
   output logic          f_rvalid_o,
   output logic [DW-1:0] f_rdata_o,
   input  logic          l_req_i,
   input  logic          l_we_i,
   input  logic          l_lock_i,
   input  logic [AW-1:0] l_addr_i,
   input  logic [DW-1:0] l_wdata_i,
   output logic          l_gnt_o,
   output logic          l_rvalid_o,
   output logic [DW-1:0] l_rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          fetch_stall_o
);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_LOCK  = 1'b1
   } state_t;

   localparam logic [7:0] MAX_RUN = 8'(MAX_FETCH_RUN);

   state_t     state;
   logic [7:0] run_cnt;
   logic       rsp_valid;
   logic       rsp_loader;
   logic       f_gnt;
   logic       l_gnt;

   // Grant decision; the reset level forces every grant low so nothing reaches the RAM.
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (rstn_i) begin
         f_gnt = 1'b0;
         l_gnt = 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               l_gnt = l_req_i & (~f_req_i | (run_cnt == MAX_RUN));
               f_gnt = f_req_i & ~l_gnt;
            end
            ST_LOCK: begin
               l_gnt = l_req_i;
               f_gnt = 1'b0;
            end
            default: begin
               l_gnt = 1'b0;
               f_gnt = 1'b0;
            end
         endcase
      end
   end

   // Memory command mux from the granted port; fetch is read-only.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (l_gnt) begin
         mem_we_o    = l_we_i;
         mem_addr_o  = l_addr_i;
         mem_wdata_o = l_wdata_i;
      end else if (f_gnt) begin
         mem_we_o    = 1'b0;
         mem_addr_o  = f_addr_i;
         mem_wdata_o = '0;
      end else begin
         mem_we_o    = 1'b0;
         mem_addr_o  = '0;
         mem_wdata_o = '0;
      end
   end

   assign f_gnt_o       = f_gnt;
   assign l_gnt_o       = l_gnt;
   assign mem_req_o     = f_gnt | l_gnt;
   assign fetch_stall_o = f_req_i & ~f_gnt & ~rstn_i;

   // Lock FSM, fetch run counter and read-response owner tracking.
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         state      <= ST_FETCH;
         run_cnt    <= 8'd0;
         rsp_valid  <= 1'b0;
         rsp_loader <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (l_gnt & l_lock_i) begin
                  state <= ST_LOCK;
               end else begin
                  state <= ST_FETCH;
               end
            end
            ST_LOCK: begin
               // The unlocking grant itself still reaches the RAM this cycle.
               if ((l_gnt & ~l_lock_i) | ~l_req_i) begin
                  state <= ST_FETCH;
               end else begin
                  state <= ST_LOCK;
               end
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase

         if (l_gnt | ~l_req_i) begin
            run_cnt <= 8'd0;
         end else if (f_gnt && (run_cnt != MAX_RUN)) begin
            run_cnt <= run_cnt + 8'd1;
         end else begin
            run_cnt <= run_cnt;
         end

         rsp_valid  <= f_gnt | (l_gnt & ~l_we_i);
         rsp_loader <= l_gnt;
      end
   end

   assign f_rvalid_o = rsp_valid & ~rsp_loader;
   assign l_rvalid_o = rsp_valid & rsp_loader;
   assign f_rdata_o  = (rsp_valid & ~rsp_loader) ? mem_rdata_i : '0;
   assign l_rdata_o  = (rsp_valid & rsp_loader) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_triumph_imem_arbiter.sv
// Randomized bench for triumph_imem_arbiter against a grant/response reference model.
// A small RAM answers the DUT's memory port; a shadow copy supplies expected read data.
module tb_triumph_imem_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MAX = 8;

   logic          clk_i  = 1'b0;
   logic          rstn_i = 1'b1;
   logic          f_req  = 1'b0;
   logic [AW-1:0] f_addr = '0;
   logic          l_req  = 1'b0;
   logic          l_we   = 1'b0;
   logic          l_lock = 1'b0;
   logic [AW-1:0] l_addr = '0;
   logic [DW-1:0] l_wdata = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic          f_gnt, f_rvalid, l_gnt, l_rvalid;
   logic          mem_req, mem_we, fetch_stall;
   logic [DW-1:0] f_rdata, l_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] ram     [64];
   logic [DW-1:0] ref_mem [64];

   int num_checks = 0;
   int num_fail   = 0;

   // stimulus knobs
   int f_pct, l_pct, lock_pct, we_pct;
   bit f_seq = 1'b0;
   int seq_addr = 0;

   // reference model: loader ownership, fetch streak while loader waits, pending response
   bit            m_owned  = 1'b0;
   int            m_streak = 0;
   bit            m_rsp_v  = 1'b0;
   bit            m_rsp_l  = 1'b0;
   logic [DW-1:0] m_rsp_d  = '0;
   bit            last_fg  = 1'b0;
   bit            last_lg  = 1'b0;

   triumph_imem_arbiter #(.AW(AW), .DW(DW), .MAX_FETCH_RUN(MAX)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
      .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
      .l_req_i(l_req), .l_we_i(l_we), .l_lock_i(l_lock), .l_addr_i(l_addr),
      .l_wdata_i(l_wdata), .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .fetch_stall_o(fetch_stall)
   );

   always #5 clk_i = ~clk_i;

   // instruction RAM with one-cycle read latency
   always @(posedge clk_i) begin
      if (mem_req) begin
         if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[5:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic zero_check();
      chk("rst_f_gnt", f_gnt, 0);       chk("rst_l_gnt", l_gnt, 0);
      chk("rst_f_rvalid", f_rvalid, 0); chk("rst_l_rvalid", l_rvalid, 0);
      chk("rst_f_rdata", f_rdata, 0);   chk("rst_l_rdata", l_rdata, 0);
      chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", fetch_stall, 0);
   endtask

   // one clock cycle: refresh requests, check against the model, advance the model
   task automatic step();
      bit ef, el;
      @(negedge clk_i);
      if (!f_req || last_fg) begin
         f_req  = ($urandom_range(99) < f_pct);
         f_addr = f_seq ? AW'(seq_addr) : AW'($urandom_range(63));
         if (f_seq && f_req) seq_addr++;
      end
      if (!l_req || last_lg) begin
         l_req   = ($urandom_range(99) < l_pct);
         l_we    = ($urandom_range(99) < we_pct);
         l_lock  = ($urandom_range(99) < lock_pct);
         l_addr  = AW'($urandom_range(63));
         l_wdata = $urandom;
      end
      #1;
      el = l_req && (m_owned || !f_req || m_streak == MAX);
      ef = f_req && !m_owned && !el;
      chk("f_gnt", f_gnt, ef);
      chk("l_gnt", l_gnt, el);
      chk("mem_req", mem_req, ef || el);
      chk("mem_we", mem_we, el && l_we);
      chk("mem_addr", mem_addr, el ? l_addr : (ef ? f_addr : '0));
      chk("mem_wdata", mem_wdata, el ? l_wdata : '0);
      chk("fetch_stall", fetch_stall, f_req && !ef);
      chk("f_rvalid", f_rvalid, m_rsp_v && !m_rsp_l);
      chk("f_rdata", f_rdata, (m_rsp_v && !m_rsp_l) ? m_rsp_d : '0);
      chk("l_rvalid", l_rvalid, m_rsp_v && m_rsp_l);
      chk("l_rdata", l_rdata, (m_rsp_v && m_rsp_l) ? m_rsp_d : '0);

      m_rsp_v = ef || (el && !l_we);
      m_rsp_l = el;
      m_rsp_d = ef ? ref_mem[f_addr[5:0]] : ref_mem[l_addr[5:0]];
      if (el && l_we) ref_mem[l_addr[5:0]] = l_wdata;
      m_owned = el && l_lock;
      if (el || !l_req)               m_streak = 0;
      else if (ef && m_streak < MAX)  m_streak++;
      last_fg = ef;
      last_lg = el;
      @(posedge clk_i);
   endtask

   // async reset hit right after an edge that granted a read
   task automatic reset_mid();
      #1 rstn_i = 1'b1;
      f_req = 1'b1;
      l_req = 1'b1;
      #1 zero_check();
      @(negedge clk_i);
      f_req = 1'b0;
      l_req = 1'b0;
      @(negedge clk_i);
      rstn_i  = 1'b0;
      m_owned = 1'b0; m_streak = 0; m_rsp_v = 1'b0;
      last_fg = 1'b0; last_lg = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram[i]     = 32'h100 + 32'(i);
         ref_mem[i] = 32'h100 + 32'(i);
      end
      f_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
      f_addr = 32'h4; l_addr = 32'h8; l_wdata = 32'hdead;
      #12 zero_check();
      f_req = 1'b0; l_req = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b0;

      // fetch only, sequential addresses 0,1,2,...
      f_pct = 100; l_pct = 0; lock_pct = 0; we_pct = 0; f_seq = 1'b1;
      repeat (5) step();
      f_seq = 1'b0;

      // continuous contention: MAX fetch grants then one loader grant
      f_pct = 100; l_pct = 100; lock_pct = 0; we_pct = 50;
      repeat (20) step();

      // mixed traffic with locked bursts and gaps
      f_pct = 70; l_pct = 50; lock_pct = 30; we_pct = 50;
      repeat (400) step();
      f_pct = 100; l_pct = 90; lock_pct = 75; we_pct = 60;
      repeat (150) step();

      // loader takes the lock with reads in flight, then reset
      f_pct = 100; l_pct = 100; lock_pct = 100; we_pct = 0;
      repeat (12) step();
      reset_mid();

      // fetch streak partly built with a fetch read in flight, then reset
      f_pct = 100; l_pct = 100; lock_pct = 0; we_pct = 50;
      repeat (13) step();
      reset_mid();
      repeat (20) step();

      f_pct = 60; l_pct = 60; lock_pct = 40; we_pct = 40;
      repeat (200) step();

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
      $finish;
   end
endmodule
